// File: rtl/sync_fifo_param.sv
//==============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with registered read data, an
//            occupancy count, full/empty/almost flags and overflow/underflow
//            status. Optional macro FIFO_STICKY_ERR_EN makes the status sticky.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wen,
   input  logic                     ren,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     error
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [WIDTH-1:0]  mem [DEPTH];

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              wr_acc;
   logic              rd_acc;
   logic              ovf_evt;
   logic              unf_evt;

   // Status flags are decoded from the registered count only.
   always_comb begin
      full         = (count_q == CNT_W'(DEPTH));
      empty        = (count_q == '0);
      almost_full  = (count_q >= CNT_W'(AF_LEVEL));
      almost_empty = (count_q <= CNT_W'(AE_LEVEL));
   end

   // A read frees a slot on the same edge, so a full FIFO still takes a write
   // alongside a read. An empty FIFO never bypasses write data to the reader.
   always_comb begin
      wr_acc  = wen && (!full || ren);
      rd_acc  = ren && !empty;
      ovf_evt = wen && full && !ren;
      unf_evt = ren && empty;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      dout_d  = dout_q;

      if (wr_acc) begin
         wptr_d = wptr_q + ADDR_W'(1);
      end

      if (rd_acc) begin
         rptr_d = rptr_q + ADDR_W'(1);
         dout_d = mem[rptr_q];
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
`ifdef FIFO_STICKY_ERR_EN
      overflow_d  = overflow_q  | ovf_evt;
      underflow_d = underflow_q | unf_evt;
`else
      overflow_d  = ovf_evt;
      underflow_d = unf_evt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         dout_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; stale contents are never readable because the
   // count gates every read.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wptr_q] <= din;
      end
   end

   always_comb begin
      dout      = dout_q;
      count     = count_q;
      overflow  = overflow_q;
      underflow = underflow_q;
      error     = overflow_q | underflow_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
//==============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8) using a
//            queue reference model and a read-data scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sync_fifo_param;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic             clk;
   logic             rst;
   logic             wen;
   logic             ren;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [3:0]       count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;
   logic             error;

   int               n_tests;
   int               n_fail;

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] sb_q    [$];
   logic [WIDTH-1:0] exp_dout;
   logic             exp_ovf;
   logic             exp_unf;

   sync_fifo_param #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wen          (wen),
      .ren          (ren),
      .din          (din),
      .dout         (dout),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow),
      .error        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp_v);
      end
   endtask

   task automatic check_state(input string tag);
      int sz;
      sz = model_q.size();
      check({tag, ".count"},  32'(count),        32'(sz));
      check({tag, ".full"},   32'(full),         32'(sz == DEPTH));
      check({tag, ".empty"},  32'(empty),        32'(sz == 0));
      check({tag, ".afull"},  32'(almost_full),  32'(sz >= AF));
      check({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= AE));
      check({tag, ".ovf"},    32'(overflow),     32'(exp_ovf));
      check({tag, ".unf"},    32'(underflow),    32'(exp_unf));
      check({tag, ".err"},    32'(error),        32'(exp_ovf | exp_unf));
      check({tag, ".dout"},   32'(dout),         32'(exp_dout));
   endtask

   task automatic model_reset();
      model_q.delete();
      sb_q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
   endtask

   // Drive one cycle of stimulus from posedge+1, predict, then check at posedge+1.
   task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
      logic m_full, m_empty, wacc, racc, ovf_e, unf_e;
      wen = w;
      ren = r;
      din = d;
      m_full  = (model_q.size() == DEPTH);
      m_empty = (model_q.size() == 0);
      wacc    = w && (!m_full || r);
      racc    = r && !m_empty;
      ovf_e   = w && m_full && !r;
      unf_e   = r && m_empty;
      if (racc) sb_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
      exp_ovf = exp_ovf | ovf_e;
      exp_unf = exp_unf | unf_e;
`else
      exp_ovf = ovf_e;
      exp_unf = unf_e;
`endif
      @(posedge clk);
      #1;
      if (racc) exp_dout = sb_q.pop_front();
      check_state(tag);
      wen = 1'b0;
      ren = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      wen = 1'b0;
      ren = 1'b0;
      din = '0;
      model_reset();

      // Reset held for two edges, then idle.
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, "idle");

      // Fill to full, then one rejected write.
      for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i), "fill");
      cycle(1'b1, 1'b0, 8'd9, "overflow");
      cycle(1'b0, 1'b0, 8'd0, "post_ovf");

      // Drain in order, then one rejected read.
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, "drain");
      cycle(1'b0, 1'b1, 8'h00, "underflow");
      cycle(1'b0, 1'b0, 8'h00, "post_unf");

      // Simultaneous read/write at mid, full and empty occupancy.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), "sim_pre");
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(10 + i), "sim_mid");
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i), "sim_fill");
      cycle(1'b1, 1'b1, 8'h3f, "sim_full");
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, "sim_drain");
      cycle(1'b1, 1'b1, 8'd7, "sim_empty");
      cycle(1'b0, 1'b1, 8'h00, "sim_rd7");

      // Alternating write/read long enough to wrap both pointers.
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b0, 8'($urandom_range(1, 255)), "wrap_wr");
         cycle(1'b0, 1'b1, 8'h00, "wrap_rd");
      end

      // Asynchronous reset pulsed between edges with data in flight.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i), "mid_fill");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_state("async_rst");
      #1 rst = 1'b0;

      // Underflow status behaviour after reset, then cleared by reset.
      cycle(1'b0, 1'b1, 8'h00, "err_set");
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, "err_hold");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_state("err_clr");
      #1 rst = 1'b0;
      cycle(1'b1, 1'b0, 8'h66, "final_wr");
      cycle(1'b0, 1'b1, 8'h00, "final_rd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
